// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state, opcode and mux-select encodings shared by the control unit
package ctrl_pkg;
  typedef enum logic [4:0] {
    S_RST, S_F1, S_F2, S_F3, S_F4, S_DEC,
    S_EXR, S_WBR, S_EXI, S_WBI, S_EXL, S_WBL,
    S_EXA, S_MR, S_MW, S_MA, S_MM,
    S_BC, S_BT, S_BW, S_J1, S_J2, S_J3, S_J4
  } state_t;
  localparam logic [3:0] OP_ADD = 4'b0000, OP_ADI = 4'b0001, OP_NDU = 4'b0010, OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW = 4'b0100, OP_SW = 4'b0101, OP_LM = 4'b0110, OP_SM = 4'b0111;
  localparam logic [3:0] OP_JAL = 4'b1000, OP_JLR = 4'b1001, OP_BEQ = 4'b1100;
  localparam logic [2:0] M1_ZERO = 3'd0, M1_ONE = 3'd1, M1_B = 3'd2, M1_IMM6 = 3'd3, M1_CNT = 3'd4;
  localparam logic [2:0] M2_ZERO = 3'd0, M2_ONE = 3'd1, M2_SHIFT7 = 3'd2, M2_IMM6 = 3'd3;
  localparam logic [2:0] M2_IMM9 = 3'd4, M2_A = 3'd5, M2_TMPA = 3'd6;
  localparam logic [1:0] M3_OFF = 2'd0, M3_ON = 2'd1, M3_CZ = 2'd2, M3_IRB = 2'd3;
  localparam logic [2:0] M4_IR119 = 3'd0, M4_IR53 = 3'd1, M4_CNT = 3'd2, M4_R7 = 3'd3, M4_IR86 = 3'd4;
  localparam logic [1:0] M5_IR86 = 2'd0, M5_CNT = 2'd1, M5_R7 = 2'd2;
  localparam logic M6_MEM = 1'b0, M6_T1 = 1'b1;
  localparam logic [1:0] M8_OFF = 2'd0, M8_ON = 2'd1, M8_IRB = 2'd2;
  localparam logic M9_A = 1'b0, M9_B = 1'b1;
endpackage

// File: rtl/control_unit_lmsm_counter.sv
// lmsm_counter: 3-bit LM/SM register index with clear, increment and last flag
module lmsm_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [2:0] count,
  output logic       last
);
  logic [2:0] count_q, count_d;
  always_comb count_d = clr ? 3'd0 : inc ? count_q + 3'd1 : count_q;
  always_ff @(posedge clk) count_q <= rst ? 3'd0 : count_d;
  assign count = count_q;
  assign last = count_q == 3'd7;
endmodule

// File: rtl/control_unit.sv
// control_unit: multicycle sequencer driving the 16-bit RISC datapath selects and enables
module control_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       compare,
  output logic [2:0] Mux1_alu_B,
  output logic [2:0] Mux2_alu_A,
  output logic [1:0] Mux3_RF_wen,
  output logic [2:0] Mux4_RF_wadd,
  output logic [1:0] Mux5_RF_read2,
  output logic       Mux6_RF_dataIn,
  output logic [1:0] Mux8_memwrite,
  output logic       Mux9_memDataIn,
  output logic       ALU_op,
  output logic       CZen,
  output logic       memRead,
  output logic       wIR,
  output logic       wtmpA,
  output logic [2:0] counter
);
  state_t state_q, state_d;
  logic [3:0] op_q, op_d;
  logic clr, inc, last;
  lmsm_counter u_cnt (.clk, .rst(reset), .clr, .inc, .count(counter), .last);
  always_comb begin
    state_d = S_F1;
    op_d = op_q;
    clr = 1'b0;
    inc = 1'b0;
    case (state_q)
      S_F1: state_d = S_F2;
      S_F2: state_d = S_F3;
      S_F3: state_d = S_F4;
      S_F4: state_d = S_DEC;
      S_DEC: begin
        op_d = opcode;
        clr = 1'b1;
        case (opcode)
          OP_ADD, OP_NDU: state_d = S_EXR;
          OP_ADI: state_d = S_EXI;
          OP_LHI: state_d = S_EXL;
          OP_LW, OP_SW: state_d = S_EXA;
          OP_LM, OP_SM: state_d = S_MA;
          OP_BEQ: state_d = S_BC;
          OP_JAL, OP_JLR: state_d = S_J1;
          default: state_d = S_F1;
        endcase
      end
      S_EXR: state_d = S_WBR;
      S_EXI: state_d = S_WBI;
      S_EXL: state_d = S_WBL;
      S_EXA: state_d = op_q == OP_LW ? S_MR : S_MW;
      S_MA: state_d = S_MM;
      S_MM: begin
        inc = 1'b1;
        state_d = last ? S_F1 : S_MA;
      end
      S_BC: state_d = compare ? S_BT : S_F1;
      S_BT: state_d = S_BW;
      S_J1: state_d = S_J2;
      S_J2: state_d = S_J3;
      S_J3: state_d = S_J4;
      default: state_d = S_F1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      op_q <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
    end
  end
  always_comb begin
    Mux1_alu_B = M1_ZERO;
    Mux2_alu_A = M2_ZERO;
    Mux3_RF_wen = M3_OFF;
    Mux4_RF_wadd = M4_IR119;
    Mux5_RF_read2 = M5_IR86;
    Mux6_RF_dataIn = M6_MEM;
    Mux8_memwrite = M8_OFF;
    Mux9_memDataIn = M9_A;
    ALU_op = 1'b0;
    CZen = 1'b0;
    memRead = 1'b0;
    wIR = 1'b0;
    wtmpA = 1'b0;
    case (state_q)
      S_F1, S_J1: begin
        Mux5_RF_read2 = M5_R7;
        Mux1_alu_B = M1_B;
      end
      S_F2: begin
        memRead = 1'b1;
        wIR = 1'b1;
      end
      S_F3: begin
        Mux2_alu_A = M2_ONE;
        Mux1_alu_B = M1_B;
        Mux5_RF_read2 = M5_R7;
      end
      S_F4, S_BW, S_J4: begin
        Mux4_RF_wadd = M4_R7;
        Mux6_RF_dataIn = M6_T1;
        Mux3_RF_wen = M3_ON;
      end
      S_DEC: wtmpA = 1'b1;
      S_EXR: begin
        ALU_op = op_q[1];
        Mux2_alu_A = M2_A;
        Mux1_alu_B = M1_B;
        CZen = 1'b1;
      end
      S_WBR: begin
        Mux3_RF_wen = M3_CZ;
        Mux4_RF_wadd = M4_IR53;
        Mux6_RF_dataIn = M6_T1;
      end
      S_EXI: begin
        Mux2_alu_A = M2_A;
        Mux1_alu_B = M1_IMM6;
        CZen = 1'b1;
      end
      S_WBI: begin
        Mux3_RF_wen = M3_ON;
        Mux4_RF_wadd = M4_IR86;
        Mux6_RF_dataIn = M6_T1;
      end
      S_EXL: Mux2_alu_A = M2_SHIFT7;
      S_WBL, S_J2: begin
        Mux3_RF_wen = M3_ON;
        Mux6_RF_dataIn = M6_T1;
      end
      S_EXA: begin
        Mux2_alu_A = M2_IMM6;
        Mux1_alu_B = M1_B;
      end
      S_MR: begin
        Mux3_RF_wen = M3_ON;
        memRead = 1'b1;
      end
      S_MW: Mux8_memwrite = M8_ON;
      S_MA: begin
        Mux2_alu_A = M2_TMPA;
        Mux1_alu_B = M1_CNT;
      end
      S_MM: begin
        Mux5_RF_read2 = op_q == OP_SM ? M5_CNT : M5_IR86;
        Mux9_memDataIn = op_q == OP_SM ? M9_B : M9_A;
        Mux8_memwrite = op_q == OP_SM ? M8_IRB : M8_OFF;
        Mux3_RF_wen = op_q == OP_SM ? M3_OFF : M3_IRB;
        Mux4_RF_wadd = op_q == OP_SM ? M4_IR119 : M4_CNT;
        memRead = op_q != OP_SM;
      end
      S_BC: begin
        Mux2_alu_A = M2_A;
        Mux1_alu_B = M1_B;
      end
      S_BT: begin
        Mux2_alu_A = M2_IMM6;
        Mux1_alu_B = M1_B;
        Mux5_RF_read2 = M5_R7;
      end
      S_J3: begin
        Mux1_alu_B = M1_B;
        Mux2_alu_A = op_q == OP_JLR ? M2_ZERO : M2_IMM9;
        Mux5_RF_read2 = op_q == OP_JLR ? M5_IR86 : M5_R7;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: vector table, directed sequences and random opcodes against a step-list model
module tb_control_unit;
  logic clk = 1'b0, reset = 1'b1, compare = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic [2:0] Mux1_alu_B, Mux2_alu_A, Mux4_RF_wadd, counter;
  logic [1:0] Mux3_RF_wen, Mux5_RF_read2, Mux8_memwrite;
  logic Mux6_RF_dataIn, Mux9_memDataIn, ALU_op, CZen, memRead, wIR, wtmpA;
  logic [21:0] act;
  int checks = 0, errors = 0, exp_cnt = 0;
  always #5 clk = ~clk;
  control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .compare(compare),
    .Mux1_alu_B(Mux1_alu_B), .Mux2_alu_A(Mux2_alu_A), .Mux3_RF_wen(Mux3_RF_wen),
    .Mux4_RF_wadd(Mux4_RF_wadd), .Mux5_RF_read2(Mux5_RF_read2), .Mux6_RF_dataIn(Mux6_RF_dataIn),
    .Mux8_memwrite(Mux8_memwrite), .Mux9_memDataIn(Mux9_memDataIn), .ALU_op(ALU_op),
    .CZen(CZen), .memRead(memRead), .wIR(wIR), .wtmpA(wtmpA), .counter(counter)
  );
  assign act = {Mux1_alu_B, Mux2_alu_A, Mux3_RF_wen, Mux4_RF_wadd, Mux5_RF_read2, Mux6_RF_dataIn,
                Mux8_memwrite, Mux9_memDataIn, ALU_op, CZen, memRead, wIR, wtmpA};
  typedef enum {T_RST, T_F1, T_F2, T_F3, T_F4, T_DEC, T_EXR, T_WBR, T_EXI, T_WBI, T_EXL, T_WBL,
                T_EXA, T_MR, T_MW, T_MA, T_MM, T_BC, T_BT, T_BW, T_J1, T_J2, T_J3, T_J4} step_t;
  typedef struct {
    logic [3:0]  op;
    logic        cmp;
    int          len;
    logic [21:0] last;
  } tv_t;
  tv_t tv[14];
  function automatic logic [21:0] vec(input int m1, m2, m3, m4, m5, m6, m8, m9, alu, cz, mr, wi, wt);
    return {3'(m1), 3'(m2), 2'(m3), 3'(m4), 2'(m5), 1'(m6), 2'(m8), 1'(m9), 1'(alu), 1'(cz), 1'(mr), 1'(wi), 1'(wt)};
  endfunction
  function automatic logic [21:0] exp_out(input step_t s, input logic [3:0] op);
    case (s)
      T_F1, T_J1: return vec(2, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
      T_F2: return vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      T_F3: return vec(2, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
      T_F4, T_BW, T_J4: return vec(0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      T_DEC: return vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      T_EXR: return vec(2, 5, 0, 0, 0, 0, 0, 0, int'(op[1]), 1, 0, 0, 0);
      T_WBR: return vec(0, 0, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      T_EXI: return vec(3, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      T_WBI: return vec(0, 0, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      T_EXL: return vec(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      T_WBL, T_J2: return vec(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      T_EXA: return vec(2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      T_MR: return vec(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      T_MW: return vec(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      T_MA: return vec(4, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      T_MM: return op == 4'h7 ? vec(0, 0, 0, 0, 1, 0, 2, 1, 0, 0, 0, 0, 0)
                              : vec(0, 0, 3, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      T_BC: return vec(2, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      T_BT: return vec(2, 3, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
      T_J3: return op == 4'h9 ? vec(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)
                              : vec(2, 4, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
      default: return 22'd0;
    endcase
  endfunction
  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask
  task automatic run_instr(input logic [3:0] op, input bit rnd, input logic cf);
    step_t q[$];
    step_t s;
    q = '{T_F1, T_F2, T_F3, T_F4, T_DEC};
    case (op)
      4'h0, 4'h2: begin q.push_back(T_EXR); q.push_back(T_WBR); end
      4'h1: begin q.push_back(T_EXI); q.push_back(T_WBI); end
      4'h3: begin q.push_back(T_EXL); q.push_back(T_WBL); end
      4'h4: begin q.push_back(T_EXA); q.push_back(T_MR); end
      4'h5: begin q.push_back(T_EXA); q.push_back(T_MW); end
      4'h6, 4'h7: for (int i = 0; i < 8; i++) begin q.push_back(T_MA); q.push_back(T_MM); end
      4'hC: q.push_back(T_BC);
      4'h8, 4'h9: begin q.push_back(T_J1); q.push_back(T_J2); q.push_back(T_J3); q.push_back(T_J4); end
      default: ;
    endcase
    opcode = op;
    while (q.size() > 0) begin
      s = q.pop_front();
      compare = rnd ? 1'($urandom_range(0, 1)) : cf;
      chk($sformatf("%s op=%h outputs", s.name(), op), 32'(act), 32'(exp_out(s, op)));
      chk($sformatf("%s op=%h counter", s.name(), op), 32'(counter), 32'(exp_cnt));
      if (s == T_DEC) exp_cnt = 0;
      if (s == T_MM) exp_cnt = (exp_cnt + 1) % 8;
      if (s == T_BC && compare) begin q.push_back(T_BT); q.push_back(T_BW); end
      @(negedge clk);
    end
  endtask
  initial begin
    tv[0]  = '{4'h0, 1'b0, 7, exp_out(T_WBR, 4'h0)};
    tv[1]  = '{4'h2, 1'b0, 7, exp_out(T_WBR, 4'h2)};
    tv[2]  = '{4'h1, 1'b0, 7, exp_out(T_WBI, 4'h1)};
    tv[3]  = '{4'h3, 1'b0, 7, exp_out(T_WBL, 4'h3)};
    tv[4]  = '{4'h4, 1'b0, 7, exp_out(T_MR, 4'h4)};
    tv[5]  = '{4'h5, 1'b0, 7, exp_out(T_MW, 4'h5)};
    tv[6]  = '{4'hC, 1'b0, 6, exp_out(T_BC, 4'hC)};
    tv[7]  = '{4'hC, 1'b1, 8, exp_out(T_BW, 4'hC)};
    tv[8]  = '{4'h8, 1'b0, 9, exp_out(T_J4, 4'h8)};
    tv[9]  = '{4'h9, 1'b1, 9, exp_out(T_J4, 4'h9)};
    tv[10] = '{4'h6, 1'b0, 21, exp_out(T_MM, 4'h6)};
    tv[11] = '{4'h7, 1'b1, 21, exp_out(T_MM, 4'h7)};
    tv[12] = '{4'hA, 1'b0, 5, exp_out(T_DEC, 4'hA)};
    tv[13] = '{4'hF, 1'b1, 5, exp_out(T_DEC, 4'hF)};
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      chk("reset outputs", 32'(act), 32'd0);
      chk("reset counter", 32'(counter), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    foreach (tv[i]) begin
      opcode = tv[i].op;
      compare = tv[i].cmp;
      repeat (tv[i].len - 1) @(negedge clk);
      chk($sformatf("vec%0d op=%h last cycle", i, tv[i].op), 32'(act), 32'(tv[i].last));
      @(negedge clk);
      chk($sformatf("vec%0d op=%h then F1", i, tv[i].op), 32'(act), 32'(exp_out(T_F1, 4'h0)));
      @(negedge clk);
      chk($sformatf("vec%0d op=%h then F2", i, tv[i].op), 32'(act), 32'(exp_out(T_F2, 4'h0)));
      opcode = 4'hF;
      repeat (4) @(negedge clk);
    end
    exp_cnt = 0;
    run_instr(4'h0, 1'b0, 1'b0);
    run_instr(4'h6, 1'b0, 1'b0);
    run_instr(4'hC, 1'b0, 1'b0);
    run_instr(4'hC, 1'b0, 1'b1);
    run_instr(4'h9, 1'b0, 1'b0);
    run_instr(4'h7, 1'b0, 1'b1);
    opcode = 4'h7;
    repeat (12) @(negedge clk);
    chk("SM 4th MM outputs", 32'(act), 32'(exp_out(T_MM, 4'h7)));
    chk("SM 4th MM counter", 32'(counter), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    chk("mid-SM reset outputs", 32'(act), 32'd0);
    chk("mid-SM reset counter", 32'(counter), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("after reset F1", 32'(act), 32'(exp_out(T_F1, 4'h0)));
    chk("after reset counter", 32'(counter), 32'd0);
    exp_cnt = 0;
    repeat (4) @(negedge clk);
    opcode = 4'hF;
    @(negedge clk);
    for (int n = 0; n < 60; n++) run_instr(4'($urandom_range(0, 15)), 1'b1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_unit.md
# control_unit

Multicycle sequencer for the 16-bit RISC datapath. Walks each instruction through fetch, decode, execute, memory and write-back states, and drives every datapath mux select, enable and the LM/SM register counter. It sits beside the datapath and sees only the opcode field and the ALU compare flag.

## Interface
- No parameters; all encodings live in the shared package.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  4  IRout[15:12] of the datapath
- compare  in  1  ALU equality flag (BEQ)
- Mux1_alu_B  out  3  0=0, 1=1, 2=B, 3=imm6, 4=counter
- Mux2_alu_A  out  3  0=0, 1=1, 2=shift7, 3=imm6, 4=imm9, 5=A, 6=tmpA
- Mux3_RF_wen  out  2  0=off, 1=on, 2=CZ-conditional, 3=IR bit[counter]
- Mux4_RF_wadd  out  3  0=IR[11:9], 1=IR[5:3], 2=counter, 3=R7, 4=IR[8:6]
- Mux5_RF_read2  out  2  0=IR[8:6], 1=counter, 2=R7
- Mux6_RF_dataIn  out  1  0=memory, 1=T1
- Mux8_memwrite  out  2  0=off, 1=on, 2=IR bit[counter]
- Mux9_memDataIn  out  1  0=A, 1=B
- ALU_op  out  1  0=add, 1=nand
- CZen, memRead, wIR, wtmpA  out  1 each  flag/memory/IR/tmpA enables
- counter  out  3  LM/SM register index

## Operation
- Outputs are Moore: a function of the state, plus the latched opcode where noted. Unlisted outputs are 0 in every state.
- RST: all outputs 0. Next state is F1.
- F1: T1←R7 (Mux5=2, Mux2=0, Mux1=2).
- F2: IR←mem[T1] (memRead, wIR).
- F3: T1←R7+1 (Mux2=1, Mux1=2, Mux5=2).
- F4: R7←T1 (Mux4=3, Mux6=1, Mux3=1).
- DEC: tmpA←RF[IR11:9] (wtmpA). counter←0. Branch on opcode.
- ADD 0000 / NDU 0010:
  - EXR: T1←A op B, with ALU_op=opcode[1], Mux2=5, Mux1=2, Mux5=0, CZen=1.
  - WBR: RF[IR5:3]←T1 with Mux3=2.
- ADI 0001:
  - EXI: T1←A+imm6, CZen=1.
  - WBI: RF[IR8:6]←T1.
- LHI 0011:
  - EXL: T1←shift7+0.
  - WBL: RF[IR11:9]←T1.
- LW 0100 / SW 0101:
  - EXA: T1←imm6+B with Mux5=0.
  - LW then goes to MR: RF[IR11:9]←mem[T1] (memRead, Mux6=0).
  - SW then goes to MW: mem[T1]←A (Mux8=1, Mux9=0).
- LM 0110 / SM 0111:
  - MA: T1←tmpA+counter.
  - LM then MM: RF[counter]←mem[T1] with Mux3=3, Mux4=2, memRead.
  - SM then MM: mem[T1]←RF[counter] with Mux5=1, Mux9=1, Mux8=2.
  - After MM, counter increments. counter==7 goes to F1, else back to MA.
  - Address is base+index for all 8 slots, whether or not the IR bit is set.
- BEQ 1100:
  - BC: ALU compares A with B (Mux5=0). compare=1 goes to BT, else F1.
  - BT: T1←R7+imm6 (R7 already PC+1).
  - BW: R7←T1.
- JAL 1000 / JLR 1001:
  - J1: T1←R7.
  - J2: RF[IR11:9]←T1.
  - J3: JAL T1←R7+imm9; JLR T1←0+B with Mux5=0.
  - J4: R7←T1.
  - Link is written before the target is read: JLR with IR11:9==IR8:6 jumps to PC+1.
- Every other opcode is a NOP: DEC goes straight to F1.
- Every final state (WBx, MR, MW, BW, J4, last MM, BC not-taken) goes to F1.

## Timing
- Reset is sampled on the rising edge. When asserted, state=RST and counter=0 on the next cycle, regardless of the current state, including mid-LM/SM.
- Instruction latency in cycles, counted from F1:
  - ADD/ADI/LHI/LW/SW: 7
  - BEQ not taken: 6; taken: 8
  - JAL/JLR: 9
  - LM/SM: 5+16 = 21
- counter changes only at the DEC clear and the MM increment. It wraps only via the exit at 7, never to 0 inside the loop.
- compare is sampled only in BC.

## Structure
- Package ctrl_pkg holds:
  - state enum, 5-bit
  - opcode constants
  - mux select constants for every select port
- Optional sub-module lmsm_counter: 3-bit counter with clr, inc and last outputs.
- The rest is a single always_ff state register plus an always_comb next-state and output decoder.

## Test plan
- Reset held 2 cycles, then released: all outputs 0 during reset; F1 on the first cycle after release (Mux5=2, Mux1=2).
- opcode=0000: sequence F1..F4, DEC, EXR, WBR; Mux3=2 and Mux4=1 in cycle 7; next cycle is F1.
- opcode=0110: MA/MM alternates 8 times; counter goes 0..7; in MM, Mux3=3 and memRead=1; F1 follows the counter==7 MM.
- opcode=1100: compare=0 returns to F1 after 6 cycles. compare=1 passes through BT and BW, and BW asserts Mux4=3, Mux3=1.
- opcode=1001: J2 asserts Mux4=0; J3 asserts Mux5=0, Mux2=0; J4 writes R7.
- reset asserted during the 4th MM of an SM: next cycle RST with counter=0 and Mux8=0; after release, fetch restarts at F1.
